delay0_fall_timer: RTL
======================

Name: delay0_fall_timer

Overview:
- Clocked digital falling-edge delay timer. It is the fall-edge counterpart of the generated fixed rise-edge RC delay cells in the soft-start path.
- A rising edge on i passes to o after synchronizer latency only.
- A falling edge on i is held off for DELAY_CYCLES clocks before o falls. Short low glitches are absorbed, which stretches enable pulses.
- Instantiated next to the analog rise-delay cells, so soft-start control gets matched rise and fall timing.

Parameters:
- DELAY_CYCLES, 100, fall delay in CELCLK cycles (1us at 100MHz). Legal range 1..2^CNT_W. A value of 0 is an elaboration error.
- CNT_W, 7, counter width. Must hold DELAY_CYCLES-1.
- SYNC_STAGES, 2, number of flops in the input synchronizer for asynchronous i. Minimum 2.

Ports:
- CELCLK  input  1  block clock, rising-edge active.
- CELRST  input  1  asynchronous active-high reset.
- i  input  1  asynchronous level input to be delayed.
- o  output  1  delayed output, registered.
- busy  output  1  high while the fall-delay countdown is in progress.
- done  output  1  one-cycle pulse when a completed countdown drives o low.

Behaviour:
- Reset (CELRST=1, asynchronous, any time): all of the following clear immediately.
  - Synchronizer flops = 0.
  - State = IDLE_LOW.
  - cnt = 0.
  - o = 0, busy = 0, done = 0.
- Reset mid-countdown aborts the countdown with no done pulse. After reset deasserts, o stays 0 until i_s is seen high.
- i_s is the output of the last synchronizer stage. The FSM sees only i_s, never i.
- All outputs are registered. o, busy and done are decoded from next-state logic so they change on the same edge as the state.
- IDLE_LOW: o=0, busy=0.
  - i_s=1 -> HIGH (o=1 next edge).
- HIGH: o=1, busy=0.
  - i_s=0 -> COUNT, load cnt = DELAY_CYCLES-1, busy=1.
- COUNT: o=1, busy=1.
  - If i_s=1 -> HIGH, busy=0, cnt unchanged, no done (retrigger).
  - Else if cnt==0 -> IDLE_LOW, o=0, busy=0, done=1 for exactly one cycle.
  - Else cnt = cnt-1.
- Simultaneous events: i_s=1 in the same cycle as cnt==0 is a retrigger. o stays 1 and done stays 0.
- Latency, rise: o rises SYNC_STAGES+1 cycles after i is first sampled high.
- Latency, fall: o falls SYNC_STAGES+DELAY_CYCLES+1 cycles after i is first sampled low, provided i stays low throughout.
- Glitch rule: any low excursion of i_s shorter than DELAY_CYCLES+1 cycles leaves o high.
- Any high excursion of i_s lasting at least 1 cycle sets o high.
- DELAY_CYCLES=1: COUNT lasts one cycle, then o falls.
- Counter never wraps. Decrement happens only when cnt>0, and the load value is bounded by the parameter check.
- Any illegal state decodes to IDLE_LOW with o=0.

Test Plan:
- Reset and hold: assert CELRST with i=1 -> o=0, busy=0, done=0 immediately. Release CELRST -> o=1 exactly 3 cycles later (SYNC_STAGES=2).
- Nominal pulse: DELAY_CYCLES=100, i high for 50 cycles, then low -> o rises at cycle 3. busy is high for 100 cycles. o falls and done pulses (1 cycle) 103 cycles after i falls.
- Glitch absorption: i low for 40 cycles mid-high -> o stays 1 throughout. busy rises, then drops on retrigger. No done pulse.
- Boundary retrigger: i_s returns high in exactly the cnt==0 cycle -> o stays 1, done=0, state HIGH. A second low of 120 cycles then completes normally, o falling 103 cycles after i falls.
- Minimum delay: DELAY_CYCLES=1, i low -> o falls 4 cycles after i falls, done pulses once.
- Reset mid-count: assert CELRST at cnt=37 -> o, busy and cnt clear immediately, no done pulse. After release with i=0, o stays 0.

Source files
------------

// File: rtl/delay0_fall_timer.sv
// Falling-edge delay timer: rising edges of i pass to o after synchronization,
// falling edges are held off for DELAY_CYCLES clocks so short low glitches are absorbed.
module delay0_fall_timer #(
    parameter int DELAY_CYCLES = 100,
    parameter int CNT_W        = 7,
    parameter int SYNC_STAGES  = 2
) (
    input  logic CELCLK,
    input  logic CELRST,
    input  logic i,
    output logic o,
    output logic busy,
    output logic done
);

    if (DELAY_CYCLES < 1 || DELAY_CYCLES > (1 << CNT_W)) begin : g_bad_delay
        $error("delay0_fall_timer: DELAY_CYCLES must be in 1..2**CNT_W");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("delay0_fall_timer: SYNC_STAGES must be at least 2");
    end

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW = 2'd0,
        HIGH     = 2'd1,
        COUNT    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   i_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             o_q, o_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i};
        end
    end

    assign i_s = sync_q[SYNC_STAGES-1];

    // A high i_s always wins over an expiring count, so a retrigger on the
    // cnt==0 cycle keeps o high and suppresses done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (i_s) state_d = HIGH;
            end
            HIGH: begin
                if (!i_s) begin
                    state_d = COUNT;
                    cnt_d   = LOAD_VAL;
                end
            end
            COUNT: begin
                if (i_s) begin
                    state_d = HIGH;
                end else if (cnt_q == '0) begin
                    state_d = IDLE_LOW;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
            end
        endcase
        o_d    = (state_d == HIGH) || (state_d == COUNT);
        busy_d = (state_d == COUNT);
    end

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o    = o_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
